iter_alu: RTL and testbench

Parametrised, multi-cycle successor to the datapath ALU. It sits between the register file/PC mux and the writeback stage. It adds width and immediate-size parameters, logical right shift, register-register add/sub and an optional shift-add multiplier. Shifts and multiplies run iteratively, one bit per cycle, under a start/busy/done handshake; all other ops complete in one cycle. Results are registered and held until the next completion.

---
 rtl/iter_alu_pkg.sv | 21 ++
 rtl/iter_alu_shmul.sv | 80 ++++++++
 rtl/iter_alu.sv | 164 ++++++++++++++++
 tb/tb_iter_alu.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/iter_alu_pkg.sv
// Shared op codes, FSM state type and widths for iter_alu.
package iter_alu_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_PASS = 3'b000;
   localparam logic [OP_W-1:0] OP_SHL  = 3'b001;
   localparam logic [OP_W-1:0] OP_SHR  = 3'b010;
   localparam logic [OP_W-1:0] OP_BRT  = 3'b011;
   localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
   localparam logic [OP_W-1:0] OP_MUL  = 3'b110;
   localparam logic [OP_W-1:0] OP_ILL  = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      MUL   = 2'd2
   } state_t;

endpackage

// File: rtl/iter_alu_shmul.sv
// Iterative shift / shift-add multiply datapath; one bit per cycle under a down-counter.
// Accumulator and multiplier register exist only when ITER_ALU_MUL_EN is defined.
module iter_alu_shmul
   import iter_alu_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_shift,
   input  logic               load_mul,
   input  logic               right,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               last_c,
   output logic [WIDTH-1:0]   shift_res_c,
   output logic [WIDTH-1:0]   mul_res_c
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] sh;
   logic             dir;
   logic [CNT_W-1:0] cnt;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic r);
      return r ? (v >> 1) : (v << 1);
   endfunction

   // The first bit moves on the load edge, so the counter starts one below the total.
   always_ff @(posedge clk) begin
      if (reset) begin
         sh  <= '0;
         dir <= 1'b0;
         cnt <= '0;
      end else if (load_shift) begin
         sh  <= step(x, right);
         dir <= right;
         cnt <= CNT_W'(shamt) - CNT_W'(1);
      end else if (load_mul) begin
         sh  <= x << 1;
         dir <= 1'b0;
         cnt <= CNT_W'(WIDTH - 1);
      end else if (cnt != '0) begin
         sh  <= step(sh, dir);
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign last_c      = (cnt == CNT_W'(1));
   assign shift_res_c = step(sh, dir);

`ifdef ITER_ALU_MUL_EN
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mplier;

   // Shift-add: sh carries the shifted multiplicand, mplier supplies one bit per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         mplier <= '0;
      end else if (load_mul) begin
         acc    <= b[0] ? x : '0;
         mplier <= b >> 1;
      end else if (cnt != '0) begin
         acc    <= acc + (mplier[0] ? sh : '0);
         mplier <= mplier >> 1;
      end
   end

   assign mul_res_c = acc + (mplier[0] ? sh : '0);
`else
   logic unused_b;
   assign unused_b  = ^b;
   assign mul_res_c = '0;
`endif

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle ops computed at accept, shifts/multiply iterate in iter_alu_shmul.
// Optional multiplier enabled by defining ITER_ALU_MUL_EN; otherwise op 110 is illegal.
module iter_alu
   import iter_alu_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned IMM_W   = 6,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic             sel_pc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] b,
   input  logic [IMM_W-1:0] imm,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             err
);

   state_t state, state_nx;

   logic [WIDTH-1:0]   x_c;
   logic [WIDTH-1:0]   sext_c;
   logic [WIDTH-1:0]   single_c;
   logic [SHAMT_W-1:0] shamt_c;
   logic               accept_c;
   logic               is_shift_c;
   logic               multi_shift_c;
   logic               is_mul_c;
   logic               ill_c;
   logic               last_c;
   logic [WIDTH-1:0]   shift_res_c;
   logic [WIDTH-1:0]   mul_res_c;

   logic               load_shift;
   logic               load_mul;
   logic               done_nx;
   logic               err_nx;
   logic [WIDTH-1:0]   res_nx;

   assign x_c           = sel_pc ? pc : a;
   assign sext_c        = WIDTH'($signed(imm));
   assign shamt_c       = imm[SHAMT_W-1:0];
   assign accept_c      = start && (state == IDLE);
   assign is_shift_c    = (op == OP_SHL) || (op == OP_SHR);
   assign multi_shift_c = is_shift_c && (shamt_c > SHAMT_W'(1));

`ifdef ITER_ALU_MUL_EN
   assign is_mul_c = (op == OP_MUL);
   assign ill_c    = (op == OP_ILL);
`else
   assign is_mul_c = 1'b0;
   assign ill_c    = (op == OP_ILL) || (op == OP_MUL);
`endif

   // Ops finishing at the accept edge; shifts here only ever see shamt 0 or 1.
   always_comb begin
      single_c = '0;
      case (op)
         OP_PASS: single_c = x_c;
         OP_SHL:  single_c = (shamt_c == '0) ? x_c : (x_c << 1);
         OP_SHR:  single_c = (shamt_c == '0) ? x_c : (x_c >> 1);
         OP_BRT:  single_c = x_c + WIDTH'(1) + sext_c;
         OP_ADD:  single_c = x_c + b;
         OP_SUB:  single_c = x_c - b;
         default: single_c = '0;
      endcase
   end

   iter_alu_shmul #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_shmul (
      .clk         (clk),
      .reset       (reset),
      .load_shift  (load_shift),
      .load_mul    (load_mul),
      .right       (op == OP_SHR),
      .x           (x_c),
      .b           (b),
      .shamt       (shamt_c),
      .last_c      (last_c),
      .shift_res_c (shift_res_c),
      .mul_res_c   (mul_res_c)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept_c) begin
               if (multi_shift_c) state_nx = SHIFT;
               else if (is_mul_c) state_nx = MUL;
            end
         end
         SHIFT:   if (last_c) state_nx = IDLE;
         MUL:     if (last_c) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load_shift = 1'b0;
      load_mul   = 1'b0;
      done_nx    = 1'b0;
      err_nx     = 1'b0;
      res_nx     = '0;
      case (state)
         IDLE: begin
            if (accept_c) begin
               if (multi_shift_c) begin
                  load_shift = 1'b1;
               end else if (is_mul_c) begin
                  load_mul = 1'b1;
               end else begin
                  done_nx = 1'b1;
                  err_nx  = ill_c;
                  res_nx  = ill_c ? '0 : single_c;
               end
            end
         end
         SHIFT: begin
            done_nx = last_c;
            res_nx  = shift_res_c;
         end
         MUL: begin
            done_nx = last_c;
            res_nx  = mul_res_c;
         end
         default: ;
      endcase
   end

   // Result flags only move on a completion; busy mirrors the upcoming state.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         zero   <= 1'b0;
         err    <= 1'b0;
      end else begin
         busy <= (state_nx != IDLE);
         done <= done_nx;
         if (done_nx) begin
            result <= res_nx;
            zero   <= (res_nx == '0);
            err    <= err_nx;
         end
      end
   end

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu (WIDTH=8, IMM_W=6).
// Honours ITER_ALU_MUL_EN for the op 110 expectations.
module tb_iter_alu;
   import iter_alu_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] op;
   logic       sel_pc;
   logic [7:0] a, pc, b;
   logic [5:0] imm;
   logic       busy, done, zero, err;
   logic [7:0] result;

   int total = 0;
   int bad   = 0;
   int lat;
   logic bseen;
   logic dseen;

   iter_alu #(.WIDTH(8), .IMM_W(6)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .sel_pc (sel_pc),
      .a      (a),
      .pc     (pc),
      .b      (b),
      .imm    (imm),
      .busy   (busy),
      .done   (done),
      .result (result),
      .zero   (zero),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one request for a single edge; returns #1 after the accepting edge.
   task automatic launch(input logic [2:0] o, input logic sp, input logic [7:0] av,
                         input logic [7:0] pv, input logic [7:0] bv, input logic [5:0] iv);
      op = o; sel_pc = sp; a = av; pc = pv; b = bv; imm = iv;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // lat counts edges from the accepting edge (1) to the edge that raised done.
   task automatic wait_done(input int lat0, output int l, output logic bs);
      l  = lat0;
      bs = busy;
      while (!done && l < 40) begin
         @(posedge clk); #1;
         l++;
         bs = bs | busy;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; sel_pc = 1'b0;
      a = '0; pc = '0; b = '0; imm = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",   busy,   0);
      chk("rst_done",   done,   0);
      chk("rst_result", result, 0);
      chk("rst_zero",   zero,   0);
      chk("rst_err",    err,    0);
      reset = 1'b0;

      // Reset mid-shift aborts the operation
      launch(OP_SHL, 1'b0, 8'h81, 8'h00, 8'h00, 6'd7);
      @(posedge clk); #1;
      chk("midshift_busy", busy, 1);
      reset = 1'b1;
      dseen = 1'b0;
      repeat (2) begin @(posedge clk); #1; dseen = dseen | done; end
      reset = 1'b0;
      repeat (8) begin @(posedge clk); #1; dseen = dseen | done; end
      chk("abort_nodone", dseen,  0);
      chk("abort_busy",   busy,   0);
      chk("abort_result", result, 0);
      chk("abort_zero",   zero,   0);
      chk("abort_err",    err,    0);

      // BRT from pc with negative immediate
      launch(OP_BRT, 1'b1, 8'h00, 8'h10, 8'h00, 6'h3E);
      wait_done(1, lat, bseen);
      chk("brt_lat",    lat,    1);
      chk("brt_result", result, 8'h0F);
      chk("brt_busy",   bseen,  0);
      chk("brt_err",    err,    0);

      // Iterative shifts
      launch(OP_SHL, 1'b0, 8'h81, 8'h00, 8'h00, 6'd3);
      wait_done(1, lat, bseen);
      chk("shl_lat",    lat,    3);
      chk("shl_result", result, 8'h08);
      chk("shl_busy",   bseen,  1);
      chk("shl_busyd",  busy,   0);
      launch(OP_SHR, 1'b0, 8'h81, 8'h00, 8'h00, 6'd3);
      wait_done(1, lat, bseen);
      chk("shr_lat",    lat,    3);
      chk("shr_result", result, 8'h10);

      // Shift amounts 0 and 1 complete in one cycle
      launch(OP_SHL, 1'b0, 8'hA5, 8'h00, 8'h00, 6'd0);
      wait_done(1, lat, bseen);
      chk("shl0_lat",    lat,    1);
      chk("shl0_result", result, 8'hA5);
      launch(OP_SHR, 1'b0, 8'h80, 8'h00, 8'h00, 6'd1);
      wait_done(1, lat, bseen);
      chk("shr1_lat",    lat,    1);
      chk("shr1_result", result, 8'h40);

      // ADD wrap to zero then back-to-back SUB on the done cycle
      launch(OP_ADD, 1'b0, 8'hFF, 8'h00, 8'h01, 6'd0);
      wait_done(1, lat, bseen);
      chk("add_lat",    lat,    1);
      chk("add_result", result, 8'h00);
      chk("add_zero",   zero,   1);
      launch(OP_SUB, 1'b0, 8'h05, 8'h00, 8'h07, 6'd0);
      chk("sub_done",   done,   1);
      chk("sub_result", result, 8'hFE);
      chk("sub_zero",   zero,   0);

      // start during a long shift is ignored
      launch(OP_SHL, 1'b0, 8'h01, 8'h00, 8'h00, 6'd7);
      @(posedge clk); #1;
      op = OP_PASS; a = 8'hFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(3, lat, bseen);
      chk("ign_lat",    lat,    7);
      chk("ign_result", result, 8'h80);
      @(posedge clk); #1;
      chk("ign_nodone", done,   0);
      chk("ign_hold",   result, 8'h80);

      // Multiply op
      launch(OP_MUL, 1'b0, 8'd13, 8'h00, 8'd11, 6'd0);
      wait_done(1, lat, bseen);
`ifdef ITER_ALU_MUL_EN
      chk("mul_lat",    lat,    8);
      chk("mul_result", result, 8'h8F);
      chk("mul_err",    err,    0);
`else
      chk("mul_lat",    lat,    1);
      chk("mul_result", result, 8'h00);
      chk("mul_err",    err,    1);
`endif

      // Illegal op then PASS clears err
      launch(OP_ILL, 1'b0, 8'h33, 8'h00, 8'h44, 6'd5);
      wait_done(1, lat, bseen);
      chk("ill_lat",    lat,    1);
      chk("ill_result", result, 8'h00);
      chk("ill_err",    err,    1);
      chk("ill_zero",   zero,   1);
      launch(OP_PASS, 1'b0, 8'h5A, 8'hC3, 8'h00, 6'd0);
      wait_done(1, lat, bseen);
      chk("pass_result", result, 8'h5A);
      chk("pass_err",    err,    0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
